flight_call_panel: RTL
======================

# flight_call_panel

Multi-seat successor to the single-seat flight-attendant call light. It latches call lights for `N_SEATS` seats and counts pending calls. It gives the attendant one "next seat to serve" index, chosen round-robin and optionally escalated by waiting time. It sits between the per-seat call/cancel button inputs and the galley attendant panel with its serve button, chime and urgent indicators.

## Interface
Parameters:
- `N_SEATS`, 8: number of seats; 2..64.
- `TIMEOUT_CYCLES`, 1000: cycles a light may stay on before the seat is flagged urgent; ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `call_button`  in  N_SEATS  per-seat call request, level-sampled each edge.
- `cancel_button`  in  N_SEATS  per-seat cancel, level-sampled each edge.
- `serve`  in  1  attendant serve pulse; clears seat `next_seat` when `next_valid`.
- `light_state`  out  N_SEATS  registered per-seat call light.
- `pending_count`  out  $clog2(N_SEATS+1)  registered popcount of `light_state`.
- `next_seat`  out  $clog2(N_SEATS)  index of the seat to serve next.
- `next_valid`  out  1  high when any light is on.
- `chime`  out  1  one-cycle pulse when any light goes off→on.
- `urgent`  out  N_SEATS  per-seat escalation flag.

## Operation
Per-seat light, evaluated every edge:
- `call` = 1 → light on. Call wins over cancel and serve in the same cycle.
- Otherwise `cancel` = 1 → off.
- Otherwise the seat is `next_seat`, with `serve` = 1 and `next_valid` = 1 → off.
- Otherwise hold.

Round-robin pointer `rr_ptr` (internal, 0..N_SEATS-1):
- `next_seat` is the first lit seat scanning upward from `rr_ptr`, wrapping at N_SEATS-1→0.
- When no seat is lit: `next_valid` = 0 and `next_seat` = 0.
- An accepted serve (`serve` ∧ `next_valid`) sets `rr_ptr` ← `next_seat`+1, wrapping to 0 at N_SEATS.
- Serve with `next_valid` = 0 is ignored; the pointer is unchanged.
- The pointer still advances if the served seat is re-lit by a simultaneous call.

Age/escalation (only with the macro):
- Each seat has a saturating age counter, width $clog2(TIMEOUT_CYCLES+1).
- The counter is cleared while the light is off and is 0 on the edge the light turns on.
- It increments each subsequent edge while the light is on and saturates at TIMEOUT_CYCLES.
- A re-call while the light is already on does not reset the age.
- `urgent[i]` = light ∧ (age == TIMEOUT_CYCLES).
- If any `urgent` bit is set, `next_seat` = lowest-index urgent seat, overriding round-robin.

`chime`: registered; high for exactly one cycle, coincident with the cycle in which one or more `light_state` bits first read 1. Several seats rising together give a single pulse.

## Timing
- Reset values: `light_state` 0, `pending_count` 0, `next_seat` 0, `next_valid` 0, `chime` 0, `urgent` 0, `rr_ptr` 0, all ages 0.
- Reset mid-operation clears everything at the next edge and produces no chime. Reset overrides all inputs.
- Button→light latency: 1 edge. `pending_count` and `chime` are consistent with `light_state` in the same cycle.
- `next_seat`/`next_valid` are combinational from registered state (lights, `rr_ptr`, ages) only. They never depend combinationally on inputs.
- `urgent[i]` rises TIMEOUT_CYCLES edges after `light_state[i]` rises.

## Configuration
- `FLIGHT_CALL_ESCALATE_EN` defined: age counters, `urgent` and the urgent override of `next_seat` are compiled in.
- Undefined: no age counters; `urgent` is tied to 0; `next_seat` is pure round-robin. `TIMEOUT_CYCLES` is accepted but unused.

## Structure
- Package `flight_call_pkg`: seat-index and count width functions (`clog2`-based), a max-seat constant of 64, and the reset-value constants.
- Sub-module `flight_call_seat`: one light latch plus its optional age counter, producing `light` and `urgent`. It is instantiated N_SEATS times with a generate loop.
- Top level holds the round-robin scan, urgent priority encoder, popcount and chime logic.

## Test plan
All scenarios use N_SEATS = 4, TIMEOUT_CYCLES = 8, macro defined unless noted.
- Reset for 2 cycles → all outputs 0; `next_valid` = 0.
- Pulse `call_button` = 4'b0100 for 1 cycle → next cycle `light_state` = 0100, `chime` = 1 for one cycle, `pending_count` = 1, `next_seat` = 2, `next_valid` = 1.
- Seat 1: call and cancel together → light on. Then cancel alone → off, `pending_count` back to its prior value, no chime on the off transition.
- Seats 0, 2, 3 lit, `rr_ptr` = 0, then three serve pulses → served in order 0, 2, 3. `rr_ptr` ends at 0. `next_valid` = 0 afterwards. A fourth serve is ignored.
- Seat 1 lit, seat 3 lit 2 cycles later, `rr_ptr` = 2 → `next_seat` = 3. Eight edges after seat 1 lit → `urgent` = 0010 and `next_seat` = 1. Without the macro → `next_seat` stays 3 and `urgent` = 0.
- Seats 0 and 3 lit with ages at 5, assert reset for 1 cycle → everything 0 next edge, no chime. Re-calling seat 0 restarts its age from 0.

Source files
------------

// File: rtl/flight_call_pkg.sv
// Shared widths and reset values for the flight_call_panel slice.
package flight_call_pkg;

    localparam int MAX_SEATS = 64;

    localparam logic LIGHT_RST   = 1'b0;
    localparam logic CHIME_RST   = 1'b0;
    localparam logic URGENT_RST  = 1'b0;
    localparam int   RR_PTR_RST  = 0;
    localparam int   COUNT_RST   = 0;

    function automatic int seat_idx_w(input int n_seats);
        return (n_seats > 1) ? $clog2(n_seats) : 1;
    endfunction

    function automatic int count_w(input int n_seats);
        return $clog2(n_seats + 1);
    endfunction

    function automatic int age_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/flight_call_seat.sv
// One seat: call light latch plus optional waiting-time escalation.
// Escalation counter is compiled in only when FLIGHT_CALL_ESCALATE_EN is defined.
module flight_call_seat
    import flight_call_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic call,
    input  logic cancel,
    input  logic serve_hit,
    output logic light,
    output logic light_next,
    output logic urgent
);

    always_comb begin
        light_next = light;
        if (call)
            light_next = 1'b1;
        else if (cancel)
            light_next = 1'b0;
        else if (serve_hit)
            light_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            light <= LIGHT_RST;
        else
            light <= light_next;
    end

`ifdef FLIGHT_CALL_ESCALATE_EN
    localparam int AW = age_w(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] AGE_LOAD = AW'(TIMEOUT_CYCLES);

    // Cycles left before escalation; reloaded while dark and on the turn-on edge.
    logic [AW-1:0] age_left;

    always_ff @(posedge clk) begin
        if (reset)
            age_left <= AGE_LOAD;
        else if (!light || !light_next)
            age_left <= AGE_LOAD;
        else if (age_left != '0)
            age_left <= age_left - 1'b1;
    end

    assign urgent = light && (age_left == '0);
`else
    assign urgent = URGENT_RST && (TIMEOUT_CYCLES >= 1);
`endif

endmodule

// File: rtl/flight_call_panel.sv
// Multi-seat call panel: per-seat lights, round-robin next-seat pick with
// optional urgent override (FLIGHT_CALL_ESCALATE_EN), popcount and chime.
module flight_call_panel
    import flight_call_pkg::*;
#(
    parameter int N_SEATS        = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_SEATS-1:0]                call_button,
    input  logic [N_SEATS-1:0]                cancel_button,
    input  logic                              serve,
    output logic [N_SEATS-1:0]                light_state,
    output logic [count_w(N_SEATS)-1:0]       pending_count,
    output logic [seat_idx_w(N_SEATS)-1:0]    next_seat,
    output logic                              next_valid,
    output logic                              chime,
    output logic [N_SEATS-1:0]                urgent
);

    localparam int SW = seat_idx_w(N_SEATS);
    localparam int CW = count_w(N_SEATS);

    logic [N_SEATS-1:0] light_next;
    logic [N_SEATS-1:0] serve_hit;
    logic [SW-1:0]      rr_ptr;
    logic [SW-1:0]      rr_seat;
    logic [SW-1:0]      urgent_seat;
    logic               rr_found;
    logic               urgent_any;
    logic               accept;
    logic [CW-1:0]      count_next;

    assign accept = serve && next_valid;

    for (genvar i = 0; i < N_SEATS; i++) begin : g_seat
        assign serve_hit[i] = accept && (next_seat == SW'(i));

        flight_call_seat #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_seat (
            .clk        (clk),
            .reset      (reset),
            .call       (call_button[i]),
            .cancel     (cancel_button[i]),
            .serve_hit  (serve_hit[i]),
            .light      (light_state[i]),
            .light_next (light_next[i]),
            .urgent     (urgent[i])
        );
    end

    // First lit seat at or above rr_ptr, wrapping past the top seat.
    always_comb begin
        int idx;
        idx      = 0;
        rr_seat  = '0;
        rr_found = 1'b0;
        for (int k = 0; k < N_SEATS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SEATS)
                idx = idx - N_SEATS;
            if (!rr_found && light_state[idx]) begin
                rr_found = 1'b1;
                rr_seat  = SW'(idx);
            end
        end
    end

    always_comb begin
        urgent_seat = '0;
        urgent_any  = 1'b0;
        for (int i = N_SEATS - 1; i >= 0; i--) begin
            if (urgent[i]) begin
                urgent_any  = 1'b1;
                urgent_seat = SW'(i);
            end
        end
    end

    assign next_valid = rr_found;
    assign next_seat  = urgent_any ? urgent_seat : rr_seat;

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= SW'(RR_PTR_RST);
        else if (accept)
            rr_ptr <= (next_seat == SW'(N_SEATS - 1)) ? '0 : next_seat + 1'b1;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < N_SEATS; i++)
            count_next = count_next + CW'(light_next[i]);
    end

    // Only a call can turn a light on, so a dark seat being called is a rising light.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count <= CW'(COUNT_RST);
            chime         <= CHIME_RST;
        end else begin
            pending_count <= count_next;
            chime         <= |(call_button & ~light_state);
        end
    end

endmodule
